// File: rtl/switch_port_rx.sv
// Receive side of a switch input port: parses DA/SA/LEN/payload frames into a
// store-and-forward byte FIFO and streams committed frames out with sop/eop.
module switch_port_rx #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       status,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SA, S_LEN, S_PAY, S_DONE, S_DISC
  } state_t;

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] MIN_HDR = (AW+1)'(3);
  localparam logic [AW:0] MIN_FRM = (AW+1)'(4);
  localparam logic [AW:0] ONE_P   = (AW+1)'(1);

  state_t      state_q, state_d;
  logic [AW:0] wr_spec_q, wr_spec_d;
  logic [AW:0] wr_cmt_q, wr_cmt_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  drop_q, drop_d;
  logic        sop_q, sop_d;
  logic [8:0]  mem [DEPTH];

  logic [AW:0] free;
  logic        len_ok, we, drop, rewind, pop;
  logic [8:0]  wdata, head;

  assign free   = DEPTH_P - (wr_spec_q - rd_q);
  // LEN byte plus LEN payload bytes must fit: data + 1 <= free.
  assign len_ok = (data != 8'd0) && ({1'b0, data} < 9'(free));
  assign head   = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_spec_q <= '0;
      wr_cmt_q  <= '0;
      rd_q      <= '0;
      rem_q     <= '0;
      drop_q    <= '0;
      sop_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_spec_q <= wr_spec_d;
      wr_cmt_q  <= wr_cmt_d;
      rd_q      <= rd_d;
      rem_q     <= rem_d;
      drop_q    <= drop_d;
      sop_q     <= sop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_spec_q[AW-1:0]] <= wdata;
  end

  always_comb begin
    state_d  = state_q;
    wr_cmt_d = wr_cmt_q;
    rem_d    = rem_q;
    we       = 1'b0;
    wdata    = {1'b0, data};
    drop     = 1'b0;
    rewind   = 1'b0;
    case (state_q)
      S_IDLE: if (status) begin
        if (free >= MIN_HDR) begin
          we      = 1'b1;
          state_d = S_SA;
        end else begin
          drop    = 1'b1;
          state_d = S_DISC;
        end
      end
      S_SA: if (status) begin
        we      = 1'b1;
        state_d = S_LEN;
      end else begin
        rewind  = 1'b1;
        drop    = 1'b1;
        state_d = S_IDLE;
      end
      S_LEN: if (status && len_ok) begin
        we      = 1'b1;
        rem_d   = data;
        state_d = S_PAY;
      end else begin
        rewind  = 1'b1;
        drop    = 1'b1;
        state_d = status ? S_DISC : S_IDLE;
      end
      S_PAY: if (status) begin
        we    = 1'b1;
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          wdata[8] = 1'b1;
          wr_cmt_d = wr_spec_q + ONE_P;
          state_d  = S_DONE;
        end
      end else begin
        rewind  = 1'b1;
        drop    = 1'b1;
        state_d = S_IDLE;
      end
      S_DONE: if (status) begin
        drop    = 1'b1;
        state_d = S_DISC;
      end else begin
        state_d = S_IDLE;
      end
      S_DISC: if (!status) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    wr_spec_d = wr_spec_q;
    if (we)     wr_spec_d = wr_spec_q + ONE_P;
    if (rewind) wr_spec_d = wr_cmt_q;
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    rd_d   = rd_q + (AW+1)'(pop);
    sop_d  = pop ? head[8] : sop_q;
  end

  // Handshake: a byte transfers on any edge where out_valid & out_ready; while
  // out_valid is high and out_ready low the head byte and flags hold still.
  always_comb begin
    out_valid = (rd_q != wr_cmt_q);
    pop       = out_valid & out_ready;
    out_data  = out_valid ? head[7:0] : 8'h00;
    out_eop   = out_valid & head[8];
    out_sop   = out_valid & sop_q;
    busy      = (free < MIN_FRM);
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_switch_port_rx.sv
// Directed bench for switch_port_rx: frames in, scoreboard of {sop,eop,byte} out.
module tb_switch_port_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       status;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic [7:0] drop_cnt;

  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  switch_port_rx #(.DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .status(status),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    data   = d;
    status = s;
    @(posedge clk);
    #1;
  endtask

  // DA, SA, LEN, n_pay payload bytes (base+i), n_extra trailing bytes, one idle.
  task automatic send_frame(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                            input logic [7:0] base, input int n_pay, input int n_extra,
                            input bit expect_out);
    if (expect_out) begin
      exp_q.push_back({2'b10, da});
      exp_q.push_back({2'b00, sa});
      exp_q.push_back({2'b00, len});
      for (int i = 0; i < n_pay; i++)
        exp_q.push_back({1'b0, (i == n_pay - 1), base + 8'(i)});
    end
    send_byte(da, 1'b1);
    send_byte(sa, 1'b1);
    send_byte(len, 1'b1);
    for (int i = 0; i < n_pay; i++) send_byte(base + 8'(i), 1'b1);
    for (int i = 0; i < n_extra; i++) send_byte(8'hEE, 1'b1);
    send_byte(8'h00, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_valid"}, out_valid, 1'b0);
  endtask

  // Scoreboard: every accepted byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {out_sop, out_eop, out_data}, 10'h3FF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("out_byte", {out_sop, out_eop, out_data}, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; data = 8'h00; status = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_sop", out_sop, 1'b0);
    check("rst_eop", out_eop, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: good frame
    out_ready = 1'b1;
    send_frame(8'h01, 8'h02, 8'd3, 8'hA0, 3, 0, 1);
    drain("t1");
    check("t1_drop", drop_cnt, 8'd0);

    // 2: truncated mid-payload
    send_frame(8'h01, 8'h02, 8'd3, 8'hA0, 2, 0, 0);
    drain("t2");
    check("t2_drop", drop_cnt, 8'd1);
    check("t2_busy", busy, 1'b0);

    // 3: LEN=0, LEN=40, then a good frame
    send_frame(8'h03, 8'h04, 8'd0, 8'h00, 0, 0, 0);
    check("t3_len0_drop", drop_cnt, 8'd2);
    send_frame(8'h05, 8'h06, 8'd40, 8'hB0, 3, 0, 0);
    check("t3_len40_drop", drop_cnt, 8'd3);
    send_frame(8'h07, 8'h08, 8'd2, 8'hC0, 2, 0, 1);
    drain("t3");
    check("t3_drop", drop_cnt, 8'd3);

    // 4: fill with out_ready low, across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send_frame(8'h10 + 8'(k), 8'h20, 8'd4, 8'h30 + 8'(4 * k), 4, 0, 1);
    check("t4_busy_free4", busy, 1'b0);
    send_frame(8'h40, 8'h41, 8'd4, 8'h42, 4, 0, 0);
    check("t4_len_nofit_drop", drop_cnt, 8'd4);
    check("t4_busy_after_rewind", busy, 1'b0);
    send_frame(8'h50, 8'h51, 8'd1, 8'h52, 1, 0, 1);
    check("t4_busy_full", busy, 1'b1);
    check("t4_hold_data", out_data, 8'h10);
    check("t4_hold_sop", out_sop, 1'b1);
    send_frame(8'h60, 8'h61, 8'd1, 8'h62, 1, 0, 0);
    check("t4_full_drop", drop_cnt, 8'd5);
    check("t4_hold_data2", out_data, 8'h10);
    out_ready = 1'b1;
    drain("t4");
    check("t4_busy_end", busy, 1'b0);

    // 5: overrun after last byte
    send_frame(8'h70, 8'h71, 8'd2, 8'h80, 2, 2, 1);
    drain("t5");
    check("t5_drop", drop_cnt, 8'd6);

    // 6: reset mid-payload with a committed frame pending
    out_ready = 1'b0;
    send_frame(8'h90, 8'h91, 8'd1, 8'h92, 1, 0, 1);
    check("t6_pending", out_valid, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'd3, 1'b1);
    send_byte(8'hA4, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", out_data, 8'h00);
    check("t6_rst_sop", out_sop, 1'b0);
    check("t6_rst_drop", drop_cnt, 8'd0);
    status = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_frame(8'hB5, 8'hB6, 8'd2, 8'hC5, 2, 0, 1);
    drain("t6");
    check("t6_drop", drop_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
